conv_window_sched: RTL and testbench

Sequencer that runs one complete valid-mode 3x3 convolution (stride 1) over an IMG_W x IMG_H image held in an external single-port pixel memory.
For each output pixel it fetches the 9-pixel window, presents it to the 9-multiplier MAC datapath (macoperation) with a start pulse, and waits for that datapath's done.
It then writes the MAC result to the output memory in raster order.
It sits between the image/result memories and the MAC, and is the only block that drives the MAC's start.

---
 rtl/conv_window_sched_pkg.sv | 20 ++
 rtl/conv_window_sched_if.sv | 33 +++
 rtl/conv_addr_gen.sv | 54 +++++
 rtl/conv_window_sched.sv | 121 ++++++++++++
 tb/tb_conv_window_sched.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_sched_pkg.sv
// Shared types for the convolution window scheduler: pixel, window and MAC result
// types reused from the MAC datapath, plus the scheduler state encoding.
package packConv;
    localparam int PIX_W = 16;
    localparam int ACC_W = 32;

    typedef logic [PIX_W-1:0] NBITS;
    typedef NBITS [8:0]       param9;
    typedef logic [ACC_W-1:0] regC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_MSTART,
        S_MWAIT,
        S_WRITE,
        S_FINISH
    } sched_state_t;
endpackage

// File: rtl/conv_window_sched_if.sv
// Bus between the scheduler and its environment: job control, pixel memory,
// MAC datapath and result memory.
interface conv_window_sched_if #(
    parameter int ADDR_W = 10
);
    import packConv::*;

    logic              start;
    logic              busy;
    logic              done;
    logic              img_re;
    logic [ADDR_W-1:0] img_addr;
    NBITS              img_rdata;
    param9             mac_inputs;
    logic              mac_start;
    logic              mac_done;
    regC               mac_p;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    regC               out_wdata;

    modport master (
        input  start, img_rdata, mac_done, mac_p,
        output busy, done, img_re, img_addr, mac_inputs, mac_start,
               out_we, out_addr, out_wdata
    );

    modport slave (
        output start, img_rdata, mac_done, mac_p,
        input  busy, done, img_re, img_addr, mac_inputs, mac_start,
               out_we, out_addr, out_wdata
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Row/column/tap counters for the 3x3 window walk; produces the pixel fetch
// address, the raster result address and end-of-window / end-of-image flags.
module conv_addr_gen #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              k_adv,
    input  logic              pix_adv,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic [3:0]        k,
    output logic              last_k,
    output logic              last_pixel
);
    localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] OW_A    = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] OW_LAST = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] OH_LAST = ADDR_W'(IMG_H - 3);

    logic [ADDR_W-1:0] row, col;
    logic [ADDR_W-1:0] kr, kc;

    assign kr         = ADDR_W'(k / 4'd3);
    assign kc         = ADDR_W'(k % 4'd3);
    assign pix_addr   = (row + kr) * W_A + col + kc;
    assign out_addr   = row * OW_A + col;
    assign last_k     = (k == 4'd8);
    assign last_pixel = (row == OH_LAST) && (col == OW_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            k   <= '0;
            row <= '0;
            col <= '0;
        end else begin
            if (k_adv)
                k <= last_k ? 4'd0 : k + 4'd1;
            // Raster advance; row runs one past the end after the final pixel,
            // which is harmless since the next job clears it.
            if (pix_adv) begin
                if (col == OW_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/conv_window_sched.sv
// Sequences a full valid-mode 3x3 convolution: fetch window, kick the MAC,
// wait for its result, write it out in raster order.
module conv_window_sched
    import packConv::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    conv_window_sched_if.master bus
);
    sched_state_t      state, state_nx;
    param9             window;
    regC               wdata_q;
    logic              cap_vld;
    logic [3:0]        cap_k;

    logic              clear, k_adv, pix_adv;
    logic              img_re, mac_start, out_we, busy, done;
    logic [ADDR_W-1:0] pix_addr, oaddr;
    logic [3:0]        k;
    logic              last_k, last_pixel;

    conv_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .k_adv      (k_adv),
        .pix_adv    (pix_adv),
        .pix_addr   (pix_addr),
        .out_addr   (oaddr),
        .k          (k),
        .last_k     (last_k),
        .last_pixel (last_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            window  <= '0;
            wdata_q <= '0;
            cap_vld <= 1'b0;
            cap_k   <= '0;
        end else begin
            state   <= state_nx;
            // Memory returns data one cycle after the read, so the tap index
            // is delayed alongside it; DRAIN lands the last tap.
            cap_vld <= img_re;
            cap_k   <= k;
            if (cap_vld)
                window[cap_k] <= bus.img_rdata;
            if (state == S_MWAIT && bus.mac_done)
                wdata_q <= bus.mac_p;
        end
    end

    always_comb begin
        state_nx  = state;
        clear     = 1'b0;
        k_adv     = 1'b0;
        pix_adv   = 1'b0;
        img_re    = 1'b0;
        mac_start = 1'b0;
        out_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    clear    = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                busy   = 1'b1;
                img_re = 1'b1;
                k_adv  = 1'b1;
                if (last_k)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                state_nx = S_MSTART;
            end
            S_MSTART: begin
                busy      = 1'b1;
                mac_start = 1'b1;
                state_nx  = S_MWAIT;
            end
            S_MWAIT: begin
                busy = 1'b1;
                if (bus.mac_done)
                    state_nx = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                out_we   = 1'b1;
                pix_adv  = 1'b1;
                state_nx = last_pixel ? S_FINISH : S_FETCH;
            end
            S_FINISH: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Addresses are gated so the bus idles at zero outside their strobes.
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.img_re     = img_re;
    assign bus.img_addr   = img_re ? pix_addr : '0;
    assign bus.mac_inputs = window;
    assign bus.mac_start  = mac_start;
    assign bus.out_we     = out_we;
    assign bus.out_addr   = out_we ? oaddr : '0;
    assign bus.out_wdata  = wdata_q;
endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched on a 4x4 image with a pixel memory
// model and a delay-programmable MAC model.
module tb_conv_window_sched;
    import packConv::*;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 10;
    localparam int OW   = W - 2;
    localparam int OH   = H - 2;
    localparam int NPIX = OW * OH;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_window_sched_if #(.ADDR_W(AW)) bus();

    conv_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned img [W*H];
    int unsigned wgt [9];
    int          mac_dly = 1;
    int          mac_cnt = 0;
    regC         mac_res = '0;
    logic        spur = 1'b0;
    NBITS        rd_q = '0;
    int          cyc = 0;

    int checks = 0;
    int errors = 0;

    wr_t         exp_wr [$];
    int unsigned exp_rd [$];
    int          start_cyc = 0;
    int          exp_lat = 0;
    int          last_we = -1;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    bit          hold_vld = 1'b0;
    param9       win_hold;
    int          run_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (bus.img_re)
            rd_q <= (bus.img_addr < AW'(W*H)) ? NBITS'(img[bus.img_addr]) : '0;
    assign bus.img_rdata = rd_q;

    function automatic regC mac_fn(input param9 x);
        longint unsigned acc = 0;
        for (int i = 0; i < 9; i++)
            acc += longint'(x[i]) * wgt[i];
        return regC'(acc >> 8);
    endfunction

    always @(posedge clk) begin
        if (reset)
            mac_cnt <= 0;
        else if (bus.mac_start) begin
            mac_cnt <= mac_dly;
            mac_res <= mac_fn(bus.mac_inputs);
        end else if (mac_cnt != 0)
            mac_cnt <= mac_cnt - 1;
    end
    assign bus.mac_done = (mac_cnt == 1) || spur;
    assign bus.mac_p    = spur ? 32'hDEAD_BEEF : mac_res;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},       bus.busy, 0);
        chk({tag, "_done"},       bus.done, 0);
        chk({tag, "_img_re"},     bus.img_re, 0);
        chk({tag, "_img_addr"},   bus.img_addr, 0);
        chk({tag, "_mac_start"},  bus.mac_start, 0);
        chk({tag, "_mac_inputs"}, bus.mac_inputs == '0, 1);
        chk({tag, "_out_we"},     bus.out_we, 0);
        chk({tag, "_out_addr"},   bus.out_addr, 0);
        chk({tag, "_out_wdata"},  bus.out_wdata, 0);
    endtask

    // Reference: window taps walk the image directly from the output coordinate.
    task automatic push_reads();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                for (int t = 0; t < 9; t++)
                    exp_rd.push_back((r + t / 3) * W + c + t % 3);
    endtask

    task automatic push_ref();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++) begin
                longint unsigned acc = 0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        acc += longint'(img[(r + dr) * W + c + dc]) * wgt[dr * 3 + dc];
                exp_wr.push_back('{r * OW + c, int'(acc >> 8)});
            end
    endtask

    task automatic push_fixed();
        exp_wr.push_back('{0, 45});
        exp_wr.push_back('{1, 54});
        exp_wr.push_back('{2, 81});
        exp_wr.push_back('{3, 90});
    endtask

    task automatic kick(input int dly);
        mac_dly = dly;
        last_we = -1;
        @(negedge clk);
        bus.start = 1'b1;
        start_cyc = cyc;
        exp_lat   = (12 + dly) * NPIX + 1;
    endtask

    task automatic run_job(input int dly, input bit spurious, input bit extra, input bit fixed);
        int  base_wr, base_done;
        bit  seen, busy_seen;
        push_reads();
        if (fixed) push_fixed(); else push_ref();
        base_wr   = wr_cnt;
        base_done = done_cnt;
        kick(dly);
        seen = 1'b0;
        for (int n = 1; n < 400 && !seen; n++) begin
            @(negedge clk);
            bus.start = extra && (n == 8 || n == 25 || n == 40);
            spur      = spurious && (n == 3 || n == 5);
            if (bus.done) seen = 1'b1;
        end
        spur = 1'b0;
        chk("done_seen", seen, 1);
        busy_seen = 1'b0;
        if (extra) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            busy_seen |= bus.busy;
        end
        chk("no_restart", busy_seen, 0);
        chk("write_count", wr_cnt - base_wr, NPIX);
        chk("done_count", done_cnt - base_done, 1);
        chk("exp_wr_left", exp_wr.size(), 0);
        chk("exp_rd_left", exp_rd.size(), 0);
    endtask

    task automatic reset_mid_job();
        int ms, base;
        bit busy_seen;
        push_reads();
        push_fixed();
        kick(5);
        ms = 0;
        for (int n = 0; n < 400 && ms < 3; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.mac_start) ms++;
        end
        chk("reached_pixel2", ms, 3);
        @(negedge clk);
        reset = 1'b1;
        exp_wr.delete();
        exp_rd.delete();
        hold_vld = 1'b0;
        run_len  = 0;
        @(negedge clk);
        reset = 1'b0;
        check_idle("after_reset");
        base = wr_cnt;
        busy_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            busy_seen |= bus.busy;
        end
        chk("no_write_after_reset", wr_cnt - base, 0);
        chk("idle_after_reset", busy_seen, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, write or done.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.img_re) begin
                    run_len++;
                    if (exp_rd.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_read addr=%0d", bus.img_addr);
                    end else
                        chk("img_addr", bus.img_addr, exp_rd.pop_front());
                end else if (run_len != 0) begin
                    chk("fetch_run_len", run_len, 9);
                    run_len = 0;
                end
                if (hold_vld)
                    chk("mac_inputs_stable", bus.mac_inputs == win_hold, 1);
                if (bus.mac_start) begin
                    hold_vld = 1'b1;
                    win_hold = bus.mac_inputs;
                end
                if (bus.out_we) begin
                    wr_cnt++;
                    hold_vld = 1'b0;
                    if (exp_wr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write addr=%0d data=%0d", bus.out_addr, bus.out_wdata);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("out_addr", bus.out_addr, e.addr);
                        chk("out_wdata", bus.out_wdata, e.data);
                    end
                    if (last_we >= 0)
                        chk("pixel_period", cyc - last_we, 12 + mac_dly);
                    last_we = cyc;
                end
                if (bus.done) begin
                    done_cnt++;
                    chk("done_latency", cyc - start_cyc, exp_lat);
                    chk("writes_left_at_done", exp_wr.size(), 0);
                end
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < W*H; i++) img[i] = i;
        for (int i = 0; i < 9; i++) wgt[i] = 256;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_job(1, 1'b0, 1'b0, 1'b1);
        run_job(5, 1'b0, 1'b0, 1'b1);
        run_job(1, 1'b0, 1'b1, 1'b1);
        reset_mid_job();
        run_job(1, 1'b0, 1'b0, 1'b1);
        run_job(1, 1'b1, 1'b0, 1'b1);

        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < W*H; i++) img[i] = $urandom_range(0, 255);
            for (int i = 0; i < 9; i++) wgt[i] = $urandom_range(0, 511);
            run_job(int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
